// File: rtl/rx_report_fifo_if.sv
// rx_report_fifo_if: receive-frame and CPU read-port signals of rx_report_fifo
interface rx_report_fifo_if #(parameter int DEPTH_LOG2 = 6);
    logic                  rx_start;
    logic                  rx_vld;
    logic [31:0]           rx_dat;
    logic                  rx_last;
    logic                  rd_en;
    logic                  rd_vld;
    logic [31:0]           rd_dat;
    logic                  empty;
    logic [DEPTH_LOG2:0]   word_cnt;
    logic [DEPTH_LOG2:0]   frame_cnt;
    logic [15:0]           drop_cnt;
    logic                  frm_err;
    modport master (
        output rx_start, rx_vld, rx_dat, rx_last, rd_en,
        input  rd_vld, rd_dat, empty, word_cnt, frame_cnt, drop_cnt, frm_err
    );
    modport slave (
        input  rx_start, rx_vld, rx_dat, rx_last, rd_en,
        output rd_vld, rd_dat, empty, word_cnt, frame_cnt, drop_cnt, frm_err
    );
endinterface

// File: rtl/rx_report_fifo.sv
// rx_report_fifo: atomic report-frame word FIFO; ALINK_RXFIFO_FRMCHK_EN adds a frame length check
module rx_report_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int FRAME_LEN  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_flush,
    rx_report_fifo_if.slave  bus
);
    localparam int AW = DEPTH_LOG2 + 1;
    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 1);
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_tmp_q, wr_tmp_d;
    logic [AW-1:0] frame_cnt_q, frame_cnt_d, word_cnt, free;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] rd_pos_q, rd_pos_d;
    logic          rd_vld_q, rd_vld_d;
    logic [31:0]   rd_dat_q, rd_dat_d;
    logic          we, commit, pop, frame_pop, clr;
    logic [31:0]   mem [2**DEPTH_LOG2];
`ifdef ALINK_RXFIFO_FRMCHK_EN
    logic          frm_err_q, frm_err_d;
    logic [AW-1:0] idx;
`endif
    assign clr       = rst || reg_flush;
    assign word_cnt  = wr_ptr_q - rd_ptr_q;
    assign free      = AW'(2**DEPTH_LOG2) - word_cnt;
    assign pop       = bus.rd_en && (word_cnt != '0);
    assign frame_pop = pop && (rd_pos_q == LAST_POS);
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_tmp_d   = wr_tmp_q;
        drop_cnt_d = drop_cnt_q;
        we         = 1'b0;
        commit     = 1'b0;
`ifdef ALINK_RXFIFO_FRMCHK_EN
        frm_err_d  = frm_err_q;
        idx        = wr_tmp_q - wr_ptr_q;
`endif
        case (state_q)
            IDLE: if (bus.rx_start) begin
                if (free >= AW'(FRAME_LEN)) begin
                    state_d  = RECV;
                    wr_tmp_d = wr_ptr_q;
                end else begin
                    state_d    = DROP;
                    drop_cnt_d = drop_cnt_q + {15'd0, drop_cnt_q != 16'hFFFF};
                end
            end
            RECV: if (bus.rx_vld) begin
`ifdef ALINK_RXFIFO_FRMCHK_EN
                // rx_last must coincide exactly with the final frame word
                if (bus.rx_last != (idx == AW'(FRAME_LEN - 1))) begin
                    frm_err_d = 1'b1;
                    state_d   = bus.rx_last ? IDLE : DROP;
                end else
`endif
                begin
                    we       = 1'b1;
                    wr_tmp_d = wr_tmp_q + AW'(1);
                    if (bus.rx_last) begin
                        wr_ptr_d = wr_tmp_q + AW'(1);
                        commit   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            DROP: if (bus.rx_vld && bus.rx_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_pos_d    = !pop ? rd_pos_q : (frame_pop ? '0 : rd_pos_q + PW'(1));
        rd_vld_d    = pop;
        rd_dat_d    = pop ? mem[rd_ptr_q[DEPTH_LOG2-1:0]] : rd_dat_q;
        frame_cnt_d = (commit && !frame_pop) ? frame_cnt_q + AW'(1) :
                      (frame_pop && !commit) ? frame_cnt_q - AW'(1) : frame_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_tmp_q    <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            rd_pos_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_tmp_q    <= wr_tmp_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_pos_q    <= rd_pos_d;
            rd_vld_q    <= rd_vld_d;
            rd_dat_q    <= rd_dat_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[wr_tmp_q[DEPTH_LOG2-1:0]] <= bus.rx_dat;
    end
`ifdef ALINK_RXFIFO_FRMCHK_EN
    always_ff @(posedge clk) begin
        frm_err_q <= clr ? 1'b0 : frm_err_d;
    end
    assign bus.frm_err = frm_err_q;
`else
    assign bus.frm_err = 1'b0;
`endif
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_dat    = rd_dat_q;
    assign bus.empty     = (word_cnt == '0);
    assign bus.word_cnt  = word_cnt;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule
